// File: rtl/pj_decode_queue_pkg.sv
// Shared constants for the decoded-instruction queue between the front end
// and the rename stage. The top and the pointer sub-module both import this.
package pj_decode_queue_pkg;

   localparam int DECODED_INSTRUCTION_WIDTH = 32;
   localparam int DECODE_QUEUE_ELS          = 32;
   localparam int DECODE_QUEUE_DEQ_LANES    = 2;
   localparam int DECODE_QUEUE_STAT_W       = 32;

endpackage

// File: rtl/pj_decode_queue_ptr.sv
// Modulo-ELS_P pointer for the decode queue. It advances by a variable amount
// each cycle and can be cleared synchronously. Because ELS_P is a power of two,
// wrap-around is simply truncation of the sum to the pointer width.
module pj_decode_queue_ptr
   import pj_decode_queue_pkg::*;
#(
   parameter int ELS_P = DECODE_QUEUE_ELS,
   parameter int INC_W = 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_clear,
   input  logic [INC_W-1:0]           i_inc,
   output logic [$clog2(ELS_P)-1:0]   o_ptr
);

   localparam int PTR_W = $clog2(ELS_P);

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptrNext;

   // Truncating the increment is safe: any bits above PTR_W are multiples of ELS_P.
   assign w_ptrNext = r_ptr + PTR_W'(i_inc);

   // Pointer register; a clear wins over the increment.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_ptr <= '0;
      end else if (i_clear) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= w_ptrNext;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/pj_decode_queue.sv
// Decoupling queue between decode and rename: one enqueue per cycle and up to
// DEQ_LANES_P in-order dequeues per cycle, with a synchronous mispredict flush
// and an occupancy count for front-end throttling.
// Optional statistics outputs are built when PJ_DECODE_QUEUE_STATS_EN is defined.
module pj_decode_queue
   import pj_decode_queue_pkg::*;
#(
   parameter int WIDTH_P     = DECODED_INSTRUCTION_WIDTH,
   parameter int ELS_P       = DECODE_QUEUE_ELS,
   parameter int DEQ_LANES_P = DECODE_QUEUE_DEQ_LANES
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic                               flush_i,
   input  logic                               v_i,
   input  logic [WIDTH_P-1:0]                 data_i,
   output logic                               ready_o,
   output logic [DEQ_LANES_P-1:0]             v_o,
   output logic [DEQ_LANES_P*WIDTH_P-1:0]     data_o,
   input  logic [$clog2(DEQ_LANES_P+1)-1:0]   yumi_cnt_i,
   output logic [$clog2(ELS_P+1)-1:0]         count_o
`ifdef PJ_DECODE_QUEUE_STATS_EN
   ,
   output logic [$clog2(ELS_P+1)-1:0]         hwm_o,
   output logic [DECODE_QUEUE_STAT_W-1:0]     full_stall_o,
   output logic [DECODE_QUEUE_STAT_W-1:0]     flush_drop_o
`endif
);

   localparam int PTR_W  = $clog2(ELS_P);
   localparam int CNT_W  = $clog2(ELS_P+1);
   localparam int YUMI_W = $clog2(DEQ_LANES_P+1);

   logic [WIDTH_P-1:0] r_mem [ELS_P];
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_countNext;
   logic [CNT_W-1:0]   w_validCnt;
   logic [PTR_W-1:0]   w_rdPtr;
   logic [PTR_W-1:0]   w_wrPtr;
   logic [YUMI_W-1:0]  w_yumiEff;
   logic [YUMI_W-1:0]  w_rdInc;
   logic               w_ready;
   logic               w_enq;

   // Readiness depends only on the registered count, so no path exists from
   // yumi or flush to ready; a full queue refuses even if it drains this cycle.
   assign w_ready = (r_count != CNT_W'(ELS_P));
   assign w_enq   = v_i & w_ready & ~flush_i;

   // Number of lanes currently presenting a valid entry.
   assign w_validCnt = (r_count < CNT_W'(DEQ_LANES_P)) ? r_count : CNT_W'(DEQ_LANES_P);

   // Clamp the consume count to what is actually held, so an illegal yumi can
   // never drive the count negative or push the read pointer past the writer.
   always_comb begin
      w_yumiEff = yumi_cnt_i;
      if (CNT_W'(yumi_cnt_i) > r_count) begin
         w_yumiEff = YUMI_W'(r_count);
      end
   end

   // Next occupancy: flush empties the queue and discards the same-cycle enqueue and yumi.
   always_comb begin
      w_countNext = r_count;
      if (flush_i) begin
         w_countNext = '0;
      end else begin
         w_countNext = r_count + CNT_W'(w_enq) - CNT_W'(w_yumiEff);
      end
   end

   assign w_rdInc = flush_i ? '0 : w_yumiEff;

   pj_decode_queue_ptr #(
      .ELS_P (ELS_P),
      .INC_W (YUMI_W)
   ) u_rdPtr (
      .i_clk     (clk_i),
      .i_reset_n (reset_n_i),
      .i_clear   (flush_i),
      .i_inc     (w_rdInc),
      .o_ptr     (w_rdPtr)
   );

   pj_decode_queue_ptr #(
      .ELS_P (ELS_P),
      .INC_W (1)
   ) u_wrPtr (
      .i_clk     (clk_i),
      .i_reset_n (reset_n_i),
      .i_clear   (flush_i),
      .i_inc     (w_enq),
      .o_ptr     (w_wrPtr)
   );

   // Occupancy register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_count <= '0;
      end else begin
         r_count <= w_countNext;
      end
   end

   // Entry storage; deliberately not reset, only written on an accepted enqueue.
   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_mem[w_wrPtr] <= data_i;
      end
   end

   // Lane k shows the entry k places behind the oldest, wrapping across the array end.
   for (genvar k = 0; k < DEQ_LANES_P; k++) begin : g_lane
      logic [PTR_W-1:0] w_idx;
      assign w_idx                         = w_rdPtr + PTR_W'(k);
      assign v_o[k]                        = (r_count > CNT_W'(k));
      assign data_o[k*WIDTH_P +: WIDTH_P]  = r_mem[w_idx];
   end

   assign ready_o = w_ready;
   assign count_o = r_count;

`ifndef SYNTHESIS
   // Consumers must never take more entries than the queue is presenting.
   a_yumiLegal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      flush_i || (CNT_W'(yumi_cnt_i) <= w_validCnt));
`endif

`ifdef PJ_DECODE_QUEUE_STATS_EN
   logic [CNT_W-1:0]               r_hwm;
   logic [DECODE_QUEUE_STAT_W-1:0] r_fullStall;
   logic [DECODE_QUEUE_STAT_W-1:0] r_flushDrop;
   logic [DECODE_QUEUE_STAT_W:0]   w_dropSum;

   // Entries lost to a flush: everything held plus the refused same-cycle input.
   assign w_dropSum = {1'b0, r_flushDrop} + (DECODE_QUEUE_STAT_W+1)'(r_count)
                      + (DECODE_QUEUE_STAT_W+1)'(v_i);

   // Statistics counters; only reset clears them, a flush does not.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_hwm       <= '0;
         r_fullStall <= '0;
         r_flushDrop <= '0;
      end else begin
         if (w_countNext > r_hwm) begin
            r_hwm <= w_countNext;
         end
         if (v_i && !w_ready && (r_fullStall != '1)) begin
            r_fullStall <= r_fullStall + 1'b1;
         end
         if (flush_i) begin
            r_flushDrop <= w_dropSum[DECODE_QUEUE_STAT_W] ? '1
                                                          : w_dropSum[DECODE_QUEUE_STAT_W-1:0];
         end
      end
   end

   assign hwm_o        = r_hwm;
   assign full_stall_o = r_fullStall;
   assign flush_drop_o = r_flushDrop;
`endif

endmodule

// File: tb/tb_pj_decode_queue.sv
// Self-checking bench for pj_decode_queue at its default configuration
// (32-bit entries, 32 deep, 2 dequeue lanes). The reference is a plain queue
// of entries: enqueue pushes, yumi pops, flush empties.
module tb_pj_decode_queue;

   localparam int W     = 32;
   localparam int ELS   = 32;
   localparam int LANES = 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              flush;
   logic              v;
   logic [W-1:0]      data;
   logic              ready;
   logic [LANES-1:0]  vOut;
   logic [LANES*W-1:0] dataOut;
   logic [1:0]        yumi;
   logic [5:0]        count;
`ifdef PJ_DECODE_QUEUE_STATS_EN
   logic [5:0]        hwm;
   logic [31:0]       fullStall;
   logic [31:0]       flushDrop;
`endif

   int checks = 0;
   int errors = 0;
   logic [W-1:0] model[$];

   // Free-running clock, posedges at 5, 15, 25, ...
   always #5 clk = ~clk;

   pj_decode_queue #(
      .WIDTH_P     (W),
      .ELS_P       (ELS),
      .DEQ_LANES_P (LANES)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .flush_i      (flush),
      .v_i          (v),
      .data_i       (data),
      .ready_o      (ready),
      .v_o          (vOut),
      .data_o       (dataOut),
      .yumi_cnt_i   (yumi),
      .count_o      (count)
`ifdef PJ_DECODE_QUEUE_STATS_EN
      ,
      .hwm_o        (hwm),
      .full_stall_o (fullStall),
      .flush_drop_o (flushDrop)
`endif
   );

   function automatic int maxYumi();
      return (model.size() < LANES) ? model.size() : LANES;
   endfunction

   function automatic logic [LANES-1:0] expValid();
      logic [LANES-1:0] e;
      for (int k = 0; k < LANES; k++) e[k] = (model.size() > k);
      return e;
   endfunction

   // Advance one clock edge and apply the queue rules to the reference.
   task automatic tick();
      int  y;
      bit  canTake;
      @(posedge clk);
      canTake = (model.size() != ELS);
      if (flush) begin
         model.delete();
      end else begin
         y = int'(yumi);
         if (y > model.size()) y = model.size();
         for (int i = 0; i < y; i++) void'(model.pop_front());
         if (v && canTake) model.push_back(data);
      end
      #1;
   endtask

   task automatic drive(input logic iv, input logic [W-1:0] id,
                        input logic [1:0] iy, input logic iflush);
      v     = iv;
      data  = id;
      yumi  = iy;
      flush = iflush;
      tick();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic doReset();
      v = 0; data = '0; yumi = 0; flush = 0;
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      model.delete();
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && model.size() > 0; i++) drive(0, '0, 2'(maxYumi()), 0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; v = 0; data = '0; yumi = 0; flush = 0;
      #3;
      checks++; if (count !== 6'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
      checks++; if (vOut !== 2'b00) begin errors++; $display("[TB] FAIL reset_v got %b expected 00", vOut); end
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", ready); end
      #4 reset_n = 1'b1;
      model.delete();
      drive(0, '0, 0, 0);
      checks++; if (count !== 6'd0) begin errors++; $display("[TB] FAIL idle_count got %0d expected 0", count); end
   endtask

   task automatic test_basic();
      drive(1, 32'hA1, 0, 0);
      checks++; if (vOut !== 2'b01) begin errors++; $display("[TB] FAIL basic_v1 got %b expected 01", vOut); end
      checks++; if (dataOut[W-1:0] !== 32'hA1) begin errors++; $display("[TB] FAIL basic_lane0 got %h expected a1", dataOut[W-1:0]); end
      drive(1, 32'hA2, 0, 0);
      checks++; if (vOut !== 2'b11) begin errors++; $display("[TB] FAIL basic_v2 got %b expected 11", vOut); end
      drive(1, 32'hA3, 0, 0);
      checks++; if (dataOut !== {32'hA2, 32'hA1}) begin errors++; $display("[TB] FAIL basic_lanes got %h expected a2/a1", dataOut); end
      checks++; if (count !== 6'd3) begin errors++; $display("[TB] FAIL basic_count got %0d expected 3", count); end
      drive(0, '0, 2, 0);
      checks++; if (dataOut[W-1:0] !== 32'hA3 || count !== 6'd1) begin errors++; $display("[TB] FAIL basic_pop got %h/%0d expected a3/1", dataOut[W-1:0], count); end
      drive(0, '0, 1, 0);
      checks++; if (count !== 6'd0 || vOut !== 2'b00) begin errors++; $display("[TB] FAIL basic_empty got %0d/%b expected 0/00", count, vOut); end
   endtask

   task automatic test_full();
      for (int i = 0; i < ELS; i++) drive(1, $urandom, 0, 0);
      checks++; if (count !== 6'd32) begin errors++; $display("[TB] FAIL full_count got %0d expected 32", count); end
      checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %b expected 0", ready); end
      drive(1, $urandom, 2, 0);
      checks++; if (count !== 6'd30) begin errors++; $display("[TB] FAIL full_refuse got %0d expected 30", count); end
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL full_reopen got %b expected 1", ready); end
      checks++; if (dataOut !== {model[1], model[0]}) begin errors++; $display("[TB] FAIL full_lanes got %h expected %h", dataOut, {model[1], model[0]}); end
      drain();
      checks++; if (count !== 6'd0) begin errors++; $display("[TB] FAIL full_drain got %0d expected 0", count); end
   endtask

   task automatic test_wrap();
      doReset();
      for (int i = 0; i < 31; i++) drive(1, $urandom, 0, 0);
      drain();
      drive(1, 32'h10, 0, 0);
      drive(1, 32'h11, 0, 0);
      checks++; if (dataOut[W-1:0] !== 32'h10) begin errors++; $display("[TB] FAIL wrap_lane0 got %h expected 10", dataOut[W-1:0]); end
      checks++; if (dataOut[2*W-1:W] !== 32'h11) begin errors++; $display("[TB] FAIL wrap_lane1 got %h expected 11", dataOut[2*W-1:W]); end
      drain();
   endtask

   task automatic test_flush();
`ifdef PJ_DECODE_QUEUE_STATS_EN
      logic [31:0] dropBefore;
`endif
      for (int i = 0; i < 5; i++) drive(1, $urandom, 0, 0);
`ifdef PJ_DECODE_QUEUE_STATS_EN
      dropBefore = flushDrop;
`endif
      v = 1; data = $urandom; yumi = 2; flush = 1;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b expected 1", ready); end
      tick();
      checks++; if (count !== 6'd0) begin errors++; $display("[TB] FAIL flush_count got %0d expected 0", count); end
      checks++; if (vOut !== 2'b00) begin errors++; $display("[TB] FAIL flush_v got %b expected 00", vOut); end
`ifdef PJ_DECODE_QUEUE_STATS_EN
      checks++; if (flushDrop !== dropBefore + 32'd6) begin errors++; $display("[TB] FAIL flush_drop got %0d expected %0d", flushDrop, dropBefore + 32'd6); end
`endif
      drive(1, 32'h55, 0, 0);
      checks++; if (dataOut[W-1:0] !== 32'h55 || count !== 6'd1) begin errors++; $display("[TB] FAIL flush_restart got %h/%0d expected 55/1", dataOut[W-1:0], count); end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] sent[$];
      logic [W-1:0] d;
      for (int i = 0; i < 4; i++) begin
         d = $urandom; sent.push_back(d); drive(1, d, 0, 0);
      end
      for (int i = 0; i < 100; i++) begin
         d = $urandom;
         checks++;
         if (dataOut[W-1:0] !== sent[0]) begin errors++; $display("[TB] FAIL steady_order got %h expected %h", dataOut[W-1:0], sent[0]); end
         void'(sent.pop_front());
         sent.push_back(d);
         drive(1, d, 1, 0);
         checks++;
         if (count !== 6'd4) begin errors++; $display("[TB] FAIL steady_count got %0d expected 4", count); end
      end
      drain();
   endtask

   task automatic test_random();
      logic [1:0] y;
      logic       f;
      for (int i = 0; i < 400; i++) begin
         f = ($urandom_range(0, 29) == 0);
         if (i < 200) y = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, maxYumi())) : 2'd0;
         else         y = 2'($urandom_range(0, maxYumi()));
         drive(1'($urandom_range(0, 3) != 0), $urandom, y, f);
         checks++;
         if (count !== 6'(model.size())) begin errors++; $display("[TB] FAIL rand_count got %0d expected %0d", count, model.size()); end
         checks++;
         if (ready !== (model.size() != ELS)) begin errors++; $display("[TB] FAIL rand_ready got %b expected %b", ready, model.size() != ELS); end
         checks++;
         if (vOut !== expValid()) begin errors++; $display("[TB] FAIL rand_v got %b expected %b", vOut, expValid()); end
         for (int k = 0; k < LANES; k++) begin
            if (k < model.size()) begin
               checks++;
               if (dataOut[k*W +: W] !== model[k]) begin errors++; $display("[TB] FAIL rand_lane%0d got %h expected %h", k, dataOut[k*W +: W], model[k]); end
            end
         end
      end
      drain();
   endtask

   task automatic test_async_reset();
      doReset();
      for (int i = 0; i < 7; i++) drive(1, $urandom, 0, 0);
      checks++; if (count !== 6'd7) begin errors++; $display("[TB] FAIL areset_pre got %0d expected 7", count); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (count !== 6'd0) begin errors++; $display("[TB] FAIL areset_count got %0d expected 0", count); end
      checks++; if (vOut !== 2'b00) begin errors++; $display("[TB] FAIL areset_v got %b expected 00", vOut); end
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_ready got %b expected 1", ready); end
      reset_n = 1'b1;
      model.delete();
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_flush();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pj_decode_queue.md
Name: pj_decode_queue

Overview:
- Parametrised decoupling queue between the front end's decoded-instruction output and the back end's rename stage.
- Generalises the current single-lane small FIFO in two ways: a width of DEQ_LANES_P dequeue lanes per cycle, and a dedicated synchronous mispredict flush port in place of the OR-into-reset arrangement.
- Exports an occupancy count for front-end throttling.

Parameters:
- WIDTH_P, DECODED_INSTRUCTION_WIDTH: entry width in bits.
- ELS_P, 32: entry count; must be a power of two, at least 4.
- DEQ_LANES_P, 2: maximum entries consumed per cycle; legal values are 1 to 4, and must not exceed ELS_P.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush on back-end mispredict
- v_i  in  1  enqueue valid
- data_i  in  WIDTH_P  enqueue data
- ready_o  out  1  queue can accept an entry this cycle
- v_o  out  DEQ_LANES_P  per-lane valid; lane 0 is the oldest entry
- data_o  out  DEQ_LANES_P*WIDTH_P  per-lane data; lane k is at bits [k*WIDTH_P +: WIDTH_P]
- yumi_cnt_i  in  $clog2(DEQ_LANES_P+1)  number of oldest entries consumed this cycle
- count_o  out  $clog2(ELS_P+1)  current occupancy

Behaviour:
- Reset (reset_n_i low, asynchronous): read pointer, write pointer and count go to 0. Outputs: v_o=0, count_o=0, ready_o=1. data_o is don't-care but must be X-free from storage; storage itself is not reset.
- Storage: ELS_P x WIDTH_P register array. Pointers are $clog2(ELS_P) bits and wrap modulo ELS_P naturally.
- Enqueue:
  - Occurs when v_i & ready_o & ~flush_i.
  - Writes data_i at the write pointer; the write pointer increments by 1.
- ready_o:
  - ready_o = (count_o != ELS_P), computed from registered count only.
  - No combinational path from yumi_cnt_i or flush_i to ready_o.
  - When full, an enqueue is refused even if a dequeue happens in the same cycle.
- Dequeue outputs:
  - v_o[k] = (count_o > k).
  - data_o lane k = entry at (read pointer + k) mod ELS_P. The index wraps across the array end.
  - No bypass: an entry enqueued in cycle N is first visible on v_o in cycle N+1.
- Consume:
  - The read pointer advances by yumi_cnt_i, modulo ELS_P.
  - yumi_cnt_i must not exceed popcount(v_o). A violation fires a simulation assertion; the RTL clamps the value to count_o.
- Count update: count_next = count + enq - yumi_cnt_eff, where yumi_cnt_eff is the clamped value. Simultaneous enqueue and dequeue are both honoured.
- Flush:
  - Takes priority over enqueue and dequeue in the same cycle.
  - Next cycle: both pointers are 0, count is 0, v_o=0.
  - Any same-cycle enqueue is dropped and any same-cycle yumi is ignored.
  - ready_o stays 1 during the flush cycle if the queue is not full; the dropped entry is the front end's responsibility, since its PC is redirected anyway.
- Reset asserted mid-operation clears state immediately, regardless of clock.
- No internal FSM beyond the pointer and count state. Fully pipelined at one enqueue and up to DEQ_LANES_P dequeues per cycle.

Optional Feature:
- Macro: PJ_DECODE_QUEUE_STATS_EN.
- When defined, three extra outputs are added:
  - hwm_o, $clog2(ELS_P+1) bits: maximum count_o seen since reset. Cleared only by reset, not by flush.
  - full_stall_o, 32 bits: number of cycles with v_i & ~ready_o. Saturates at all ones.
  - flush_drop_o, 32 bits: number of valid entries discarded by flushes, counting count plus any same-cycle v_i. Saturating.
- When not defined, none of these ports or their logic exist; behaviour is otherwise identical.

Decomposition:
- Shared package Purple_Jade_pkg.svh gains:
  - localparam DECODE_QUEUE_ELS = 32
  - localparam DECODE_QUEUE_DEQ_LANES = 2
- Sub-module pj_decode_queue_ptr:
  - Parametrised modulo-ELS_P pointer with an increment-by-N input and a synchronous clear.
  - Instanced twice: read pointer with N=yumi_cnt_eff, write pointer with N=enq.

Test Plan:
- Reset, then enqueue 0xA1,0xA2,0xA3 on consecutive cycles with yumi_cnt_i=0:
  - v_o=2'b11 one cycle after 0xA2 is written.
  - data_o lanes = {0xA2,0xA1}; count_o=3.
- Fill 32 entries:
  - ready_o=0 at count 32.
  - v_i=1 with yumi_cnt_i=2 in the same cycle gives count 30 and no enqueue.
  - The next cycle has ready_o=1.
- Wrap-around:
  - Advance pointers to 31 with the queue empty, then enqueue 0x10,0x11.
  - Lane0=0x10 (index 31) and lane1=0x11 (index 0).
- Flush with count 5 plus v_i=1 and yumi_cnt_i=2 in the same cycle:
  - Next cycle count_o=0 and v_o=0.
  - With stats enabled, flush_drop_o increments by 6.
- Simultaneous enqueue and yumi_cnt_i=1 at steady occupancy 4 for 100 cycles:
  - count_o stays 4.
  - Output order matches input order exactly.
- reset_n_i pulsed low between clock edges while count is 7:
  - count_o=0 and v_o=0 immediately, before the next edge.
